uart_mc_hw: RTL and testbench



---
 rtl/uart_mc_pkg.sv | 22 ++
 rtl/uart_mc_ch.sv | 245 ++++++++++++++++++++++++
 rtl/uart_mc_hw.sv | 85 ++++++++
 tb/tb_uart_mc_hw.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_mc_pkg.sv
// Shared encodings for the multi-channel UART: bus op codes, command codes,
// read-word status bit positions and the per-channel FSM states.
package uart_mc_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    localparam logic [1:0] CMDGETUSAGE  = 2'd0;
    localparam logic [1:0] CMDSETRXINTR = 2'd1;
    localparam logic [1:0] CMDSETSPEED  = 2'd2;
    localparam logic [1:0] CMDSETTXINTR = 2'd3;

    localparam int unsigned VALIDBIT = 8;
    localparam int unsigned FERRBIT  = 9;
    localparam int unsigned OVRBIT   = 10;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_mc_ch.sv
// One 8N1 UART channel: TX/RX FIFOs, baud divisors, interrupt thresholds,
// overrun flag and the two serial FSMs.
module uart_mc_ch
    import uart_mc_pkg::*;
#(
    parameter int unsigned ARCHBITSZ = 32,
    parameter int unsigned BUFSZ     = 16,
    parameter int unsigned CLKFREQ   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_i,
    input  logic                 rd_i,
    input  logic                 cmd_i,
    input  logic [ARCHBITSZ-1:0] data_i,
    input  logic                 intr_clr_i,
    input  logic                 rx_i,
    output logic                 tx_o,
    output logic [ARCHBITSZ-1:0] rdata_o,
    output logic                 intr_o
);
    localparam int unsigned ArgW = ARCHBITSZ - 2;
    localparam int unsigned AW   = $clog2(BUFSZ);
    localparam int unsigned UW   = AW + 1;
    localparam logic [UW-1:0] Full = UW'(BUFSZ);

    logic [1:0]      cmd;
    logic [ArgW-1:0] arg;
    assign cmd = data_i[ARCHBITSZ-1 -: 2];
    assign arg = data_i[ArgW-1:0];

    logic [ArgW-1:0] rx_thr_q, tx_thr_q, tx_div_q, rx_div_q;
    logic            ovr_q;

    // TX FIFO
    logic [7:0]    txf_mem [BUFSZ];
    logic [AW-1:0] txf_wp_q, txf_rp_q;
    logic [UW-1:0] txf_cnt_q;
    logic          txf_push, txf_pop;

    // RX FIFO, entries are {ferr, byte}
    logic [8:0]    rxf_mem [BUFSZ];
    logic [AW-1:0] rxf_wp_q, rxf_rp_q;
    logic [UW-1:0] rxf_cnt_q;
    logic          rxf_push, rxf_pop, rx_ovf;

    tx_state_e       tx_st_q;
    logic [ArgW-1:0] tx_cnt_q, tx_lat_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_sh_q;
    logic            tx_q;

    rx_state_e       rx_st_q;
    logic [ArgW-1:0] rx_cnt_q, rx_lat_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic            rx_push_q;
    logic [8:0]      rx_pdata_q;
    logic            rx_s1_q, rx_s2_q, rx_s3_q;

    assign txf_pop  = (tx_st_q == TxIdle) && (tx_div_q != '0) && (txf_cnt_q != '0);
    assign txf_push = wr_i && ((txf_cnt_q != Full) || txf_pop);
    assign rxf_pop  = rd_i && (rxf_cnt_q != '0);
    assign rxf_push = rx_push_q && ((rxf_cnt_q != Full) || rxf_pop);
    assign rx_ovf   = rx_push_q && !rxf_push;

    always_ff @(posedge clk_i) begin
        if (txf_push) txf_mem[txf_wp_q] <= data_i[7:0];
        if (rxf_push) rxf_mem[rxf_wp_q] <= rx_pdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            txf_wp_q  <= '0;
            txf_rp_q  <= '0;
            txf_cnt_q <= '0;
            rxf_wp_q  <= '0;
            rxf_rp_q  <= '0;
            rxf_cnt_q <= '0;
        end else begin
            if (txf_push) txf_wp_q <= txf_wp_q + 1'b1;
            if (txf_pop)  txf_rp_q <= txf_rp_q + 1'b1;
            txf_cnt_q <= txf_cnt_q + UW'(txf_push) - UW'(txf_pop);
            if (rxf_push) rxf_wp_q <= rxf_wp_q + 1'b1;
            if (rxf_pop)  rxf_rp_q <= rxf_rp_q + 1'b1;
            rxf_cnt_q <= rxf_cnt_q + UW'(rxf_push) - UW'(rxf_pop);
        end
    end

    // A command in the same cycle as an acknowledge edge overrides the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_thr_q <= '0;
            tx_thr_q <= '0;
            tx_div_q <= '0;
            rx_div_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (intr_clr_i) begin
                rx_thr_q <= '0;
                tx_thr_q <= '0;
            end
            if (cmd_i) begin
                case (cmd)
                    CMDSETRXINTR: rx_thr_q <= arg;
                    CMDSETSPEED: begin
                        tx_div_q <= arg;
                        rx_div_q <= arg + (arg >> 5);
                    end
                    CMDSETTXINTR: tx_thr_q <= arg;
                    default: ;
                endcase
            end
            if (rd_i)   ovr_q <= 1'b0;
            if (rx_ovf) ovr_q <= 1'b1;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (cmd_i) begin
            case (cmd)
                CMDGETUSAGE: rdata_o = ARCHBITSZ'(arg[0] ? txf_cnt_q : rxf_cnt_q);
                CMDSETSPEED: rdata_o = ARCHBITSZ'(CLKFREQ);
                default:     rdata_o = ARCHBITSZ'(BUFSZ);
            endcase
        end else begin
            if (rxf_cnt_q != '0) begin
                rdata_o[7:0]     = rxf_mem[rxf_rp_q][7:0];
                rdata_o[VALIDBIT] = 1'b1;
                rdata_o[FERRBIT]  = rxf_mem[rxf_rp_q][8];
            end
            rdata_o[OVRBIT] = ovr_q;
        end
    end

    assign intr_o = ((rx_thr_q != '0) && (ArgW'(rxf_cnt_q) >= rx_thr_q)) ||
                    ((tx_thr_q != '0) && (ArgW'(txf_cnt_q) < tx_thr_q));

    // tx_o trails the state by one cycle so the line is fully registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_st_q  <= TxIdle;
            tx_cnt_q <= '0;
            tx_lat_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (tx_st_q)
                TxIdle: begin
                    if (txf_pop) begin
                        tx_sh_q  <= txf_mem[txf_rp_q];
                        tx_lat_q <= tx_div_q;
                        tx_cnt_q <= '0;
                        tx_bit_q <= '0;
                        tx_st_q  <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == tx_lat_q - 1'b1) begin
                        tx_cnt_q <= '0;
                        tx_st_q  <= TxData;
                    end else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                TxData: begin
                    if (tx_cnt_q == tx_lat_q - 1'b1) begin
                        tx_cnt_q <= '0;
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) tx_st_q <= TxStop;
                    end else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                TxStop: begin
                    if (tx_cnt_q == tx_lat_q - 1'b1) tx_st_q <= TxIdle;
                    else tx_cnt_q <= tx_cnt_q + 1'b1;
                end
                default: tx_st_q <= TxIdle;
            endcase
            tx_q <= (tx_st_q == TxStart) ? 1'b0 : (tx_st_q == TxData) ? tx_sh_q[0] : 1'b1;
        end
    end

    assign tx_o = tx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= '0;
            rx_lat_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_push_q  <= 1'b0;
            rx_pdata_q <= '0;
        end else begin
            rx_push_q <= 1'b0;
            case (rx_st_q)
                RxIdle: begin
                    if ((rx_div_q != '0) && rx_s3_q && !rx_s2_q) begin
                        rx_lat_q <= rx_div_q;
                        rx_cnt_q <= '0;
                        rx_st_q  <= RxStart;
                    end
                end
                RxStart: begin
                    // Mid-start check rejects glitches shorter than half a bit.
                    if (rx_cnt_q == (rx_lat_q >> 1)) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_s2_q ? RxIdle : RxData;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                RxData: begin
                    if (rx_cnt_q == rx_lat_q - 1'b1) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RxStop;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                RxStop: begin
                    if (rx_cnt_q == rx_lat_q - 1'b1) begin
                        rx_push_q  <= 1'b1;
                        rx_pdata_q <= {!rx_s2_q, rx_sh_q};
                        rx_st_q    <= RxIdle;
                    end else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                default: rx_st_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_mc_hw.sv
// Multi-channel UART on a pi1 slave port: channel decode, registered read
// data, acknowledge edge detection and the shared interrupt line.
module uart_mc_hw
    import uart_mc_pkg::*;
#(
    parameter int unsigned ARCHBITSZ = 32,
    parameter int unsigned NCHAN     = 2,
    parameter int unsigned BUFSZ     = 16,
    parameter int unsigned CLKFREQ   = 1,
    parameter int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
    output logic                   intrqst_o,
    input  logic                   intrdy_i,
    input  logic [NCHAN-1:0]       rx_i,
    output logic [NCHAN-1:0]       tx_o
);
    localparam int unsigned W   = $clog2(64 / ARCHBITSZ);
    localparam int unsigned ChW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [ChW-1:0]       ch_sel;
    logic [NCHAN-1:0]     hit, ch_intr;
    logic [ARCHBITSZ-1:0] ch_rdata [NCHAN];
    logic [ARCHBITSZ-1:0] rsel;
    logic [ARCHBITSZ-1:0] data_q;
    logic                 intrdy_q, intr_clr;
    logic                 unused_ok;

    assign ch_sel    = pi1_addr_i[W +: ChW];
    assign intr_clr  = intrdy_q && !intrdy_i;
    assign unused_ok = ^{pi1_sel_i, pi1_addr_i};

    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        assign hit[i] = (NCHAN == 1) || (ch_sel == ChW'(i));

        uart_mc_ch #(
            .ARCHBITSZ(ARCHBITSZ),
            .BUFSZ    (BUFSZ),
            .CLKFREQ  (CLKFREQ)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_i      (hit[i] && (pi1_op_i == PIWROP)),
            .rd_i      (hit[i] && (pi1_op_i == PIRDOP)),
            .cmd_i     (hit[i] && (pi1_op_i == PIRWOP)),
            .data_i    (pi1_data_i),
            .intr_clr_i(intr_clr),
            .rx_i      (rx_i[i]),
            .tx_o      (tx_o[i]),
            .rdata_o   (ch_rdata[i]),
            .intr_o    (ch_intr[i])
        );
    end

    always_comb begin
        rsel = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (hit[i]) rsel = ch_rdata[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            intrdy_q <= 1'b0;
        end else begin
            intrdy_q <= intrdy_i;
            if ((pi1_op_i == PIRDOP) || (pi1_op_i == PIRWOP)) data_q <= rsel;
        end
    end

    assign pi1_data_o  = data_q;
    assign pi1_rdy_o   = 1'b1;
    assign pi1_mapsz_o = ADDRBITSZ'(NCHAN * (64 / ARCHBITSZ));
    assign intrqst_o   = |ch_intr;

endmodule

// File: tb/tb_uart_mc_hw.sv
// Directed bench for uart_mc_hw: TX framing, RX status, overrun, interrupts,
// glitch rejection and reset mid-frame.
module tb_uart_mc_hw;
    localparam int unsigned AB  = 32;
    localparam int unsigned NC  = 2;
    localparam int unsigned BS  = 4;
    localparam int unsigned CF  = 1234;
    localparam int unsigned ADW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    op;
    logic [ADW-1:0] addr;
    logic [AB-1:0] wdata, rdata;
    logic [3:0]    sel;
    logic          rdy, intr, intrdy;
    logic [ADW-1:0] mapsz;
    logic [NC-1:0] rx, tx;

    int n_asrt = 0;
    int n_fail = 0;

    uart_mc_hw #(
        .ARCHBITSZ(AB),
        .NCHAN    (NC),
        .BUFSZ    (BS),
        .CLKFREQ  (CF),
        .ADDRBITSZ(ADW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pi1_op_i   (op),
        .pi1_addr_i (addr),
        .pi1_data_i (wdata),
        .pi1_data_o (rdata),
        .pi1_sel_i  (sel),
        .pi1_rdy_o  (rdy),
        .pi1_mapsz_o(mapsz),
        .intrqst_o  (intr),
        .intrdy_i   (intrdy),
        .rx_i       (rx),
        .tx_o       (tx)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [1:0] o, input int ch, input logic [31:0] d);
        op    = o;
        addr  = ADW'(ch * 2);
        wdata = d;
        tick();
        op    = 2'b00;
    endtask

    function automatic logic [31:0] cmdw(input logic [1:0] c, input int unsigned a);
        return {c, 30'(a)};
    endfunction

    task automatic send_rx(input int ch, input logic [7:0] b, input logic stop);
        rx[ch] = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx[ch] = b[i];
            tick(16);
        end
        rx[ch] = stop;
        tick(16);
        rx[ch] = 1'b1;
        tick(6);
    endtask

    logic [7:0] pat;
    bit         seen;

    initial begin
        rst = 1'b1; op = 2'b00; addr = '0; wdata = '0; sel = '1;
        intrdy = 1'b0; rx = '1;
        tick(3);
        rst = 1'b0;

        check("rst_tx", 32'(tx), 32'h3);
        check("rst_data", rdata, 32'h0);
        check("rst_intr", 32'(intr), 32'h0);
        check("rdy", 32'(rdy), 32'h1);
        check("mapsz", 32'(mapsz), 32'h4);

        // Channel 1 TX of 0x55 at divisor 16
        bus(2'b11, 1, cmdw(2, 16));
        check("setspeed_ch1", rdata, CF);
        bus(2'b01, 1, 32'h55);
        check("tx_n", 32'(tx), 32'h3);
        tick();
        check("tx_n1", 32'(tx), 32'h3);
        tick();
        check("tx_n2_start", 32'(tx), 32'h1);
        tick(8);
        check("tx_start_mid", 32'(tx[1]), 32'h0);
        pat = 8'h55;
        for (int k = 0; k < 8; k++) begin
            tick(16);
            check($sformatf("tx_bit%0d", k), 32'(tx), {30'h0, pat[k], 1'b1});
        end
        tick(16);
        check("tx_stop", 32'(tx), 32'h3);
        tick(20);

        // Channel 0 RX with good and bad stop
        bus(2'b11, 0, cmdw(2, 16));
        send_rx(0, 8'hA3, 1'b1);
        bus(2'b10, 0, 0);
        check("rx_good", rdata, 32'h1A3);
        send_rx(0, 8'hA3, 1'b0);
        bus(2'b10, 0, 0);
        check("rx_ferr", rdata, 32'h3A3);
        bus(2'b10, 0, 0);
        check("rx_empty", rdata, 32'h0);

        // Overrun with a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_rx(0, 8'(8'h10 + i), 1'b1);
        bus(2'b11, 0, cmdw(0, 0));
        check("ovr_usage", rdata, 32'h4);
        bus(2'b10, 0, 0);
        check("ovr_rd1", rdata, 32'h511);
        for (int i = 2; i <= 4; i++) begin
            bus(2'b10, 0, 0);
            check($sformatf("ovr_rd%0d", i), rdata, 32'(32'h110 + i));
        end

        // RX threshold interrupt and acknowledge disarm
        bus(2'b11, 0, cmdw(1, 2));
        check("setrxintr_ret", rdata, BS);
        send_rx(0, 8'h21, 1'b1);
        check("rxintr_1byte", 32'(intr), 32'h0);
        send_rx(0, 8'h22, 1'b1);
        check("rxintr_2byte", 32'(intr), 32'h1);
        intrdy = 1'b1;
        tick();
        check("rxintr_ack_hi", 32'(intr), 32'h1);
        intrdy = 1'b0;
        tick();
        check("rxintr_disarm", 32'(intr), 32'h0);
        bus(2'b11, 0, cmdw(0, 0));
        check("rxintr_usage", rdata, 32'h2);
        bus(2'b10, 0, 0);
        check("rxintr_rd", rdata, 32'h121);
        bus(2'b10, 0, 0);

        // TX low-water interrupt on channel 1, transmitter held off first
        bus(2'b11, 1, cmdw(2, 0));
        bus(2'b11, 1, cmdw(3, 1));
        check("settxintr_ret", rdata, BS);
        check("txintr_empty", 32'(intr), 32'h1);
        for (int i = 1; i <= 4; i++) bus(2'b01, 1, 32'(i));
        check("txintr_full", 32'(intr), 32'h0);
        bus(2'b11, 1, cmdw(0, 1));
        check("tx_usage4", rdata, 32'h4);
        bus(2'b11, 1, cmdw(2, 16));
        tick(300);
        check("txintr_draining", 32'(intr), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            tick();
            seen = intr;
        end
        check("txintr_drained", 32'(seen), 32'h1);
        intrdy = 1'b1;
        tick();
        intrdy = 1'b0;
        tick();
        check("txintr_disarm", 32'(intr), 32'h0);
        tick(200);

        // Glitch rejection at divisor 100
        bus(2'b11, 0, cmdw(2, 100));
        check("setspeed100", rdata, CF);
        rx[0] = 1'b0;
        tick();
        rx[0] = 1'b1;
        tick(200);
        bus(2'b11, 0, cmdw(0, 0));
        check("glitch_usage", rdata, 32'h0);

        // Reset in the middle of a TX frame
        bus(2'b01, 1, 32'h00);
        bus(2'b01, 1, 32'h00);
        tick(20);
        check("midframe_low", 32'(tx[1]), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_tx", 32'(tx), 32'h3);
        check("rst_mid_data", rdata, 32'h0);
        bus(2'b11, 1, cmdw(0, 1));
        check("rst_mid_usage", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
